// File: rtl/if_prefetch_queue.sv
// Decoupled instruction prefetch queue feeding the IF/ID register.
// Tracks in-flight fetches so responses made stale by a redirect are dropped.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_inst,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_pc_plus4,
    output logic        misaligned_pc
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam logic [CW:0] LIMIT = CW1'(DEPTH);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HALT  = 1'b1;

    logic [0:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   exp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] out_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW:0]   credit;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          head_valid;

    logic [31:0] q_inst [DEPTH];
    logic [31:0] q_pc   [DEPTH];
    logic [31:0] q_pc4  [DEPTH];

    // Credits cover both buffered and in-flight words, so a push always has room.
    assign credit = {1'b0, count} + {1'b0, outstanding};

    assign imem_req_valid = !rst && (state == ST_FETCH)
                            && !redirect_valid && (credit < LIMIT);
    assign imem_req_addr  = fetch_pc;
    assign misaligned_pc  = (state == ST_HALT);

    assign req_fire = imem_req_valid && imem_req_ready;
    assign push     = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign out_nxt  = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    assign head_valid   = (count != '0);
    assign deq_valid    = head_valid && !redirect_valid;
    assign pop          = deq_valid && deq_ready;
    assign deq_inst     = deq_valid ? q_inst[rd_ptr] : 32'h0;
    assign deq_pc       = deq_valid ? q_pc[rd_ptr]   : 32'h0;
    assign deq_pc_plus4 = deq_valid ? q_pc4[rd_ptr]  : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            exp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_nxt;
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path.
                drop     <= out_nxt;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= redirect_pc;
                exp_pc   <= redirect_pc;
                if (redirect_pc[1:0] != 2'b00) begin
                    state <= ST_HALT;
                end else begin
                    state <= ST_FETCH;
                end
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    exp_pc <= exp_pc + 32'd4;
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]   <= exp_pc;
            q_pc4[wr_ptr]  <= exp_pc + 32'd4;
        end
    end

    credit_bound: assert property (@(posedge clk) disable iff (rst) credit <= LIMIT);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: latency memory model plus in-order scoreboard.
// Expected PCs are queued by the stimulus; a negedge monitor checks every pop.
module tb_if_prefetch_queue;
    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc_plus4;
    logic        misaligned_pc;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int lat   = 1;
    int cyc   = 0;
    int acc_cnt = 0;
    int a0;
    logic [31:0] acc_log [$];
    logic [31:0] sb_q [$];
    logic [31:0] pq_addr [$];
    int          pq_due [$];
    logic        mv;
    logic [31:0] md;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_pc_plus4(deq_pc_plus4),
        .misaligned_pc(misaligned_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory keeps presenting garbage responses while reset is held.
    assign imem_rsp_valid = rst | mv;
    assign imem_rsp_data  = rst ? 32'hDEAD_DEAD : md;

    initial begin : mem_model
        mv = 1'b0;
        md = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                pq_addr.delete();
                pq_due.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                pq_addr.push_back(imem_req_addr);
                pq_due.push_back(cyc + lat);
                acc_log.push_back(imem_req_addr);
                acc_cnt++;
            end
            #1;
            mv = 1'b0;
            if (!rst && pq_due.size() > 0 && pq_due[0] == cyc + 1) begin
                mv = 1'b1;
                md = word_of(pq_addr[0]);
                void'(pq_addr.pop_front());
                void'(pq_due.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        total++;
        if (act < min) begin
            bad++;
            $display("FAIL %s actual=%0d required>=%0d", name, act, min);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && deq_valid && deq_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop actual pc=%h required none", deq_pc);
            end else begin
                logic [31:0] p;
                p = sb_q.pop_front();
                chk("deq_pc", deq_pc, p);
                chk("deq_pc_plus4", deq_pc_plus4, p + 32'd4);
                chk("deq_inst", deq_inst, word_of(p));
                pops++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] base, input int n);
        sb_q.delete();
        for (int i = 0; i < n; i++) sb_q.push_back(base + 32'(4 * i));
    endtask

    task automatic do_reset(input int l, input logic rdy);
        rst = 1'b1;
        lat = l;
        deq_ready = rdy;
        redirect_valid = 1'b0;
        sb_q.delete();
        tick(2);
        acc_cnt = 0;
        acc_log.delete();
        expect_seq(32'h0, 32);
        pops = 0;
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt, input int n_exp);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        sb_q.delete();
        if (n_exp > 0) expect_seq(tgt, n_exp);
        pops = 0;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        deq_ready = 1'b1;
        #1;
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("reset_deq_valid", {31'b0, deq_valid}, 32'h0);
        chk("reset_misaligned", {31'b0, misaligned_pc}, 32'h0);
        chk("reset_deq_pc", deq_pc, 32'h0);

        // 1: streaming, L=1
        do_reset(1, 1'b1);
        tick(1);
        chk("t1_deq_valid_early", {31'b0, deq_valid}, 32'h0);
        tick(1);
        chk("t1_deq_valid_latency", {31'b0, deq_valid}, 32'h1);
        tick(10);
        chk("t1_req0", acc_log[0], 32'h0);
        chk("t1_req1", acc_log[1], 32'h4);
        chk("t1_req2", acc_log[2], 32'h8);
        chk_ge("t1_pops", pops, 8);

        // 2: back-pressure fills the queue, L=2
        do_reset(2, 1'b0);
        tick(12);
        chk("t2_acc_cnt", 32'(acc_cnt), 32'd4);
        chk("t2_req3", acc_log[3], 32'hC);
        chk("t2_req_valid_low", {31'b0, imem_req_valid}, 32'h0);
        chk("t2_count", 32'(dut.count), 32'd4);
        chk("t2_head_stable_pc", deq_pc, 32'h0);
        chk("t2_head_stable_inst", deq_inst, word_of(32'h0));
        deq_ready = 1'b1;
        tick(16);
        chk("t2_resume_addr", acc_log[4], 32'h10);
        chk_ge("t2_pops", pops, 8);

        // 3: redirect with three requests in flight, L=3
        do_reset(3, 1'b1);
        tick(3);
        chk("t3_outstanding", 32'(acc_cnt), 32'd3);
        redirect(32'h100, 32);
        tick(1);
        redirect_valid = 1'b0;
        tick(15);
        chk("t3_first_new_req", acc_log[3], 32'h100);
        chk_ge("t3_pops", pops, 5);

        // 4: misaligned redirect halts, aligned redirect resumes
        do_reset(1, 1'b1);
        tick(5);
        redirect(32'h102, 0);
        tick(1);
        redirect_valid = 1'b0;
        chk("t4_misaligned_set", {31'b0, misaligned_pc}, 32'h1);
        chk("t4_halt_req_valid", {31'b0, imem_req_valid}, 32'h0);
        a0 = acc_cnt;
        tick(5);
        chk("t4_no_requests", 32'(acc_cnt), 32'(a0));
        chk("t4_still_halted", {31'b0, misaligned_pc}, 32'h1);
        redirect(32'h200, 32);
        tick(1);
        redirect_valid = 1'b0;
        chk("t4_misaligned_clr", {31'b0, misaligned_pc}, 32'h0);
        tick(10);
        chk_ge("t4_pops", pops, 5);

        // 5: redirect lands on a response while ID is ready
        do_reset(1, 1'b1);
        tick(6);
        chk("t5_head_before", {31'b0, deq_valid}, 32'h1);
        redirect(32'h300, 32);
        #1;
        chk("t5_rsp_coincident", {31'b0, imem_rsp_valid}, 32'h1);
        chk("t5_deq_forced_low", {31'b0, deq_valid}, 32'h0);
        tick(1);
        redirect_valid = 1'b0;
        tick(10);
        chk_ge("t5_pops", pops, 5);

        // 6: reset mid-burst with two outstanding, L=2
        do_reset(2, 1'b1);
        tick(2);
        chk("t6_outstanding", 32'(acc_cnt), 32'd2);
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("t6_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("t6_deq_valid", {31'b0, deq_valid}, 32'h0);
        chk("t6_misaligned", {31'b0, misaligned_pc}, 32'h0);
        chk("t6_deq_inst", deq_inst, 32'h0);
        chk("t6_deq_pc", deq_pc, 32'h0);
        chk("t6_deq_pc_plus4", deq_pc_plus4, 32'h0);
        tick(3);
        acc_cnt = 0;
        acc_log.delete();
        expect_seq(32'h0, 32);
        pops = 0;
        rst = 1'b0;
        tick(10);
        chk("t6_restart_addr", acc_log[0], 32'h0);
        chk_ge("t6_pops", pops, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
